// File: rtl/ula_pkg.sv
// Shared opcodes, FSM state encoding and multi-cycle opcode for the ALU
// sequencing controller.
package ula_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    // Only the multiplier uses the start/done handshake.
    localparam logic [2:0] OP_MC = OP_MUL;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_WAIT_MC,
        ST_DONE
    } state_e;

    function automatic logic is_multicycle(input logic [2:0] op);
        return op == OP_MC;
    endfunction

endpackage

// File: rtl/ula_watchdog.sv
// WAIT_MC watchdog: counts cycles while run_i is high and flags the cycle in
// which TIMEOUT_CYCLES have been spent without a done.
module ula_watchdog
    import ula_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    output logic expired_o
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter reads 0 in the first WAIT_MC cycle, so expiry lands on the
    // TIMEOUT_CYCLES-th cycle.
    assign expired_o = run_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if (run_i && !expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ula_controle.sv
// ALU sequencing controller: accepts an op, drives the mux select bus, runs the
// multiplier handshake and returns result plus flags. Optional watchdog: ULA_TIMEOUT_EN.
module ula_controle
    import ula_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [2:0]       sel,
    output logic             start_mc,
    input  logic             mc_done,
    input  logic [WIDTH-1:0] mux_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_err
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("ula_controle: TIMEOUT_CYCLES must be at least 1");
    end

    state_e           state_q;
    logic [2:0]       sel_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic             start_mc_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_result_q;
    logic             out_zero_q;
    logic             out_neg_q;
    logic             out_err_q;
    logic             timeout_hit;

`ifdef ULA_TIMEOUT_EN
    ula_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .run_i     (state_q == ST_WAIT_MC),
        .expired_o (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    assign in_ready   = (state_q == ST_IDLE);
    assign sel        = sel_q;
    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign start_mc   = start_mc_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_zero   = out_zero_q;
    assign out_neg    = out_neg_q;
    assign out_err    = out_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            start_mc_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_zero_q   <= 1'b0;
            out_neg_q    <= 1'b0;
            out_err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        sel_q     <= in_op;
                        op_a_q    <= in_a;
                        op_b_q    <= in_b;
                        out_err_q <= 1'b0;
                        if (is_multicycle(in_op)) begin
                            state_q    <= ST_WAIT_MC;
                            start_mc_q <= 1'b1;
                        end else begin
                            state_q <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    out_result_q <= mux_y;
                    out_zero_q   <= (mux_y == '0);
                    out_neg_q    <= mux_y[WIDTH-1];
                    out_valid_q  <= 1'b1;
                    state_q      <= ST_DONE;
                end
                ST_WAIT_MC: begin
                    start_mc_q <= 1'b0;
                    // start_mc_q high marks the first WAIT_MC cycle, where done is not yet trusted.
                    if (!start_mc_q && mc_done) begin
                        out_result_q <= mux_y;
                        out_zero_q   <= (mux_y == '0);
                        out_neg_q    <= mux_y[WIDTH-1];
                        out_valid_q  <= 1'b1;
                        state_q      <= ST_DONE;
                    end else if (timeout_hit) begin
                        out_result_q <= '0;
                        out_zero_q   <= 1'b1;
                        out_neg_q    <= 1'b0;
                        out_err_q    <= 1'b1;
                        out_valid_q  <= 1'b1;
                        state_q      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_controle.sv
// Directed self-checking bench for ula_controle; covers ULA_TIMEOUT_EN when
// the macro is defined for the build.
module tb_ula_controle;

    localparam int unsigned WIDTH          = 8;
    localparam int unsigned TIMEOUT_CYCLES = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [2:0]       sel;
    logic             start_mc;
    logic             mc_done;
    logic [WIDTH-1:0] mux_y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_neg;
    logic             out_err;

    int checks = 0;
    int errors = 0;

    ula_controle #(
        .WIDTH          (WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .op_a       (op_a),
        .op_b       (op_b),
        .sel        (sel),
        .start_mc   (start_mc),
        .mc_done    (mc_done),
        .mux_y      (mux_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] y,
                         input logic z, input logic n);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; mux_y = y;
        tick();
        in_valid = 1'b0;
        chk({tag, ".sel"}, 32'(sel), 32'(op));
        chk({tag, ".op_a"}, 32'(op_a), 32'(a));
        chk({tag, ".op_b"}, 32'(op_b), 32'(b));
        chk({tag, ".in_ready_settle"}, 32'(in_ready), 32'd0);
        chk({tag, ".valid_settle"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".result"}, 32'(out_result), 32'(y));
        chk({tag, ".zero"}, 32'(out_zero), 32'(z));
        chk({tag, ".neg"}, 32'(out_neg), 32'(n));
        chk({tag, ".err"}, 32'(out_err), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".valid_after"}, 32'(out_valid), 32'd0);
        chk({tag, ".in_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
        mc_done = 1'b0; mux_y = '0; out_ready = 1'b0;
        tick(); tick();
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.sel", 32'(sel), 32'd0);
        chk("rst.op_a", 32'(op_a), 32'd0);
        chk("rst.op_b", 32'(op_b), 32'd0);
        chk("rst.start_mc", 32'(start_mc), 32'd0);
        chk("rst.result", 32'(out_result), 32'd0);
        chk("rst.zero", 32'(out_zero), 32'd0);
        chk("rst.neg", 32'(out_neg), 32'd0);
        chk("rst.err", 32'(out_err), 32'd0);
        rst_n = 1'b1;
        tick();

        do_op("add",      3'b000, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0);
        do_op("sub_zero", 3'b001, 8'h03, 8'h03, 8'h00, 1'b1, 1'b0);
        do_op("sub_neg",  3'b001, 8'h02, 8'h03, 8'hFF, 1'b0, 1'b1);
        do_op("shl",      3'b110, 8'h81, 8'h00, 8'h02, 1'b0, 1'b0);
        do_op("xor",      3'b100, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b1);

        // MUL: done asserted in the first WAIT_MC cycle must be ignored.
        in_valid = 1'b1; in_op = 3'b111; in_a = 8'h0C; in_b = 8'h0A; mux_y = 8'h11;
        tick();
        in_valid = 1'b0; mc_done = 1'b1;
        chk("mul.start", 32'(start_mc), 32'd1);
        chk("mul.sel", 32'(sel), 32'd7);
        chk("mul.in_ready", 32'(in_ready), 32'd0);
        tick();
        mc_done = 1'b0;
        chk("mul.early_done_ignored", 32'(out_valid), 32'd0);
        chk("mul.start_once_a", 32'(start_mc), 32'd0);
        tick();
        chk("mul.start_once_b", 32'(start_mc), 32'd0);
        tick();
        chk("mul.wait_valid", 32'(out_valid), 32'd0);
        tick();
        mc_done = 1'b1; mux_y = 8'h78;
        chk("mul.start_once_c", 32'(start_mc), 32'd0);
        tick();
        mc_done = 1'b0;
        chk("mul.valid", 32'(out_valid), 32'd1);
        chk("mul.result", 32'(out_result), 32'h78);
        chk("mul.zero", 32'(out_zero), 32'd0);
        chk("mul.neg", 32'(out_neg), 32'd0);
        chk("mul.start_done", 32'(start_mc), 32'd0);

        // Backpressure on the MUL result with a pending request.
        in_valid = 1'b1; in_op = 3'b000; in_a = 8'hFF; in_b = 8'hFF; mux_y = 8'h55;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp.valid", 32'(out_valid), 32'd1);
            chk("bp.result", 32'(out_result), 32'h78);
            chk("bp.in_ready", 32'(in_ready), 32'd0);
            chk("bp.sel", 32'(sel), 32'd7);
            chk("bp.op_a", 32'(op_a), 32'h0C);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp.release_valid", 32'(out_valid), 32'd0);
        chk("bp.release_in_ready", 32'(in_ready), 32'd1);
        chk("bp.release_sel", 32'(sel), 32'd7);

        // done outside WAIT_MC has no effect.
        mc_done = 1'b1;
        tick(); tick();
        mc_done = 1'b0;
        chk("stray_done.valid", 32'(out_valid), 32'd0);
        chk("stray_done.in_ready", 32'(in_ready), 32'd1);

        in_valid = 1'b1; in_op = 3'b111; in_a = 8'h01; in_b = 8'h02; mux_y = 8'h9A;
        tick();
        in_valid = 1'b0;
`ifdef ULA_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("to.waiting", 32'(out_valid), 32'd0);
        end
        tick();
        chk("to.valid", 32'(out_valid), 32'd1);
        chk("to.result", 32'(out_result), 32'd0);
        chk("to.zero", 32'(out_zero), 32'd1);
        chk("to.neg", 32'(out_neg), 32'd0);
        chk("to.err", 32'(out_err), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("to.err_held_idle", 32'(out_err), 32'd1);
        do_op("to.clear", 3'b010, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0);
        in_valid = 1'b1; in_op = 3'b111; in_a = 8'h03; in_b = 8'h04;
        tick();
        in_valid = 1'b0;
        tick(); tick();
`else
        for (int i = 0; i < 100; i++) begin
            tick();
        end
        chk("no_to.valid", 32'(out_valid), 32'd0);
        chk("no_to.in_ready", 32'(in_ready), 32'd0);
        chk("no_to.err", 32'(out_err), 32'd0);
`endif

        // Reset in the middle of WAIT_MC.
        chk("pre_rst.waiting", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        chk("mid_rst.in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst.valid", 32'(out_valid), 32'd0);
        chk("mid_rst.sel", 32'(sel), 32'd0);
        chk("mid_rst.start", 32'(start_mc), 32'd0);
        chk("mid_rst.op_a", 32'(op_a), 32'd0);
        chk("mid_rst.err", 32'(out_err), 32'd0);
        rst_n = 1'b1;
        mc_done = 1'b1; mux_y = 8'h42;
        tick(); tick();
        mc_done = 1'b0;
        chk("late_done.valid", 32'(out_valid), 32'd0);
        chk("late_done.in_ready", 32'(in_ready), 32'd1);
        chk("late_done.result", 32'(out_result), 32'd0);

        do_op("or", 3'b011, 8'h80, 8'h01, 8'h81, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
